// File: rtl/gray_step_decoder.sv
// gray_step_decoder
// Receive end of a Gray-coded counter link. The asynchronous Gray bus is
// brought into the clk domain through a two-flop synchroniser and debounced
// by a stability filter. Each accepted value is decoded to binary and
// classified as an up step, a down step or an illegal jump. A signed
// position accumulator and a saturating error counter are kept alongside.

module gray_step_decoder #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int POS_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 step_valid,
  output logic                 step_up,
  output logic                 step_err,
  output logic [POS_WIDTH-1:0] position,
  output logic [7:0]           err_count
);

  // The stability counter only has to reach STABLE_CYCLES-1, so it is sized
  // for that value; a one-cycle window still needs a one-bit counter.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [WIDTH-1:0] DIFF_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIFF_DOWN = '1;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] accepted;

  logic [WIDTH-1:0]     cand_bin;
  logic [WIDTH-1:0]     diff;
  logic                 stable;
  logic                 accept;
  logic                 load;
  logic                 step_valid_next;
  logic                 step_err_next;
  logic                 step_up_next;
  logic [POS_WIDTH-1:0] position_next;
  logic [7:0]           err_count_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchroniser for the asynchronous Gray bus, nothing in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  end

  // Debounce: restart the window whenever the synced value moves, otherwise
  // count up and park at the top once the value has held long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Step classification and next-value computation for every tracked output.
  always_comb begin
    cand_bin        = gray2bin(cand);
    diff            = cand_bin - binary_out;
    stable          = (cnt == CNT_MAX);
    accept          = stable && ((cand != accepted) || (state == ST_INIT));
    state_next      = state;
    load            = 1'b0;
    step_valid_next = 1'b0;
    step_err_next   = 1'b0;
    step_up_next    = step_up;
    position_next   = position;
    err_count_next  = err_count;
    case (state)
      ST_INIT: begin
        if (accept) begin
          load       = 1'b1;
          state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept) begin
          load = 1'b1;
          if (diff == DIFF_UP) begin
            step_valid_next = 1'b1;
            step_up_next    = 1'b1;
            position_next   = position + POS_WIDTH'(1);
          end else if (diff == DIFF_DOWN) begin
            step_valid_next = 1'b1;
            step_up_next    = 1'b0;
            position_next   = position - POS_WIDTH'(1);
          end else begin
            step_err_next  = 1'b1;
            err_count_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Output and tracking registers; pulses fall back to zero every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted   <= '0;
      binary_out <= '0;
      step_valid <= 1'b0;
      step_up    <= 1'b0;
      step_err   <= 1'b0;
      position   <= '0;
      err_count  <= '0;
    end else begin
      if (load) begin
        accepted   <= cand;
        binary_out <= cand_bin;
      end
      step_valid <= step_valid_next;
      step_err   <= step_err_next;
      step_up    <= step_up_next;
      position   <= position_next;
      err_count  <= err_count_next;
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
// tb_gray_step_decoder
// Directed bench for gray_step_decoder with WIDTH=4, STABLE_CYCLES=4,
// POS_WIDTH=16. Inputs change on the falling edge; pulses are counted one
// time unit after each rising edge.

module tb_gray_step_decoder;

  localparam int WIDTH         = 4;
  localparam int STABLE_CYCLES = 4;
  localparam int POS_WIDTH     = 16;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     gray_in;
  logic [WIDTH-1:0]     binary_out;
  logic                 step_valid;
  logic                 step_up;
  logic                 step_err;
  logic [POS_WIDTH-1:0] position;
  logic [7:0]           err_count;

  int checks;
  int errors;
  int nv;
  int ne;
  int both;

  gray_step_decoder #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES),
    .POS_WIDTH    (POS_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .binary_out(binary_out),
    .step_valid(step_valid),
    .step_up   (step_up),
    .step_err  (step_err),
    .position  (position),
    .err_count (err_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count output pulses shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (step_valid) nv++;
    if (step_err) ne++;
    if (step_valid && step_err) both++;
  end

  // Drive a Gray value at the current falling edge and hold it n cycles.
  task automatic hold(input logic [WIDTH-1:0] g, input int n);
    gray_in = g;
    repeat (n) @(negedge clk);
  endtask

  // Reset with a given input held, release, let INIT accept it, clear counters.
  task automatic do_reset(input logic [WIDTH-1:0] g);
    @(negedge clk);
    rst     = 1'b1;
    gray_in = g;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    nv = 0;
    ne = 0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    gray_in = 4'b0110;
    repeat (3) @(negedge clk);
    checks++;
    if (binary_out !== 4'd0 || position !== 16'd0 || err_count !== 8'd0 ||
        step_valid !== 1'b0 || step_err !== 1'b0 || step_up !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: bin=%0d pos=%0d errc=%0d sv=%0b se=%0b su=%0b, expected all 0",
               binary_out, position, err_count, step_valid, step_err, step_up);
    end
    nv  = 0;
    ne  = 0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (binary_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL init_early: binary_out=%0d expected 0", binary_out);
    end
    @(negedge clk);
    checks++;
    if (binary_out !== 4'd4) begin
      errors++;
      $display("[TB] FAIL init_accept: binary_out=%0d expected 4", binary_out);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (nv !== 0 || ne !== 0 || position !== 16'd0) begin
      errors++;
      $display("[TB] FAIL init_silent: valid=%0d err=%0d pos=%0d expected 0 0 0", nv, ne, position);
    end
  endtask

  task automatic test_up_steps();
    do_reset(4'b0000);
    gray_in = 4'b0001;
    repeat (6) @(negedge clk);
    checks++;
    if (binary_out !== 4'd0 || step_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: bin=%0d sv=%0b expected 0 0", binary_out, step_valid);
    end
    @(negedge clk);
    checks++;
    if (binary_out !== 4'd1 || step_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_edge: bin=%0d sv=%0b expected 1 1", binary_out, step_valid);
    end
    repeat (3) @(negedge clk);
    hold(4'b0011, 10);
    hold(4'b0010, 10);
    checks++;
    if (nv !== 3 || ne !== 0 || step_up !== 1'b1 || position !== 16'd3 || binary_out !== 4'd3) begin
      errors++;
      $display("[TB] FAIL up_steps: valid=%0d err=%0d up=%0b pos=%0d bin=%0d expected 3 0 1 3 3",
               nv, ne, step_up, position, binary_out);
    end
  endtask

  task automatic test_wrap();
    do_reset(4'b1000);
    hold(4'b0000, 10);
    checks++;
    if (nv !== 1 || step_up !== 1'b1 || position !== 16'd1 || binary_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wrap_up: valid=%0d up=%0b pos=%0d bin=%0d expected 1 1 1 0",
               nv, step_up, position, binary_out);
    end
    hold(4'b1000, 10);
    checks++;
    if (nv !== 2 || step_up !== 1'b0 || position !== 16'd0 || binary_out !== 4'd15) begin
      errors++;
      $display("[TB] FAIL wrap_down: valid=%0d up=%0b pos=%0d bin=%0d expected 2 0 0 15",
               nv, step_up, position, binary_out);
    end
    hold(4'b1001, 10);
    checks++;
    if (position !== 16'hFFFF || binary_out !== 4'd14 || ne !== 0) begin
      errors++;
      $display("[TB] FAIL pos_negative: pos=%0h bin=%0d err=%0d expected ffff 14 0",
               position, binary_out, ne);
    end
  endtask

  task automatic test_glitch();
    do_reset(4'b0000);
    hold(4'b0001, 2);
    hold(4'b0000, 12);
    checks++;
    if (nv !== 0 || ne !== 0 || binary_out !== 4'd0) begin
      errors++;
      $display("[TB] FAIL glitch: valid=%0d err=%0d bin=%0d expected 0 0 0", nv, ne, binary_out);
    end
  endtask

  task automatic test_illegal();
    do_reset(4'b0000);
    hold(4'b0101, 10);
    checks++;
    if (ne !== 1 || nv !== 0 || err_count !== 8'd1 || position !== 16'd0 || binary_out !== 4'd6) begin
      errors++;
      $display("[TB] FAIL illegal_jump: err=%0d valid=%0d errc=%0d pos=%0d bin=%0d expected 1 0 1 0 6",
               ne, nv, err_count, position, binary_out);
    end
    for (int k = 0; k < 260; k++) begin
      hold((k % 2 == 0) ? 4'b0000 : 4'b0101, 8);
      if (k == 252) begin
        checks++;
        if (err_count !== 8'd254) begin
          errors++;
          $display("[TB] FAIL err_count_254: err_count=%0d expected 254", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255 || ne !== 261 || nv !== 0 || position !== 16'd0) begin
      errors++;
      $display("[TB] FAIL err_saturate: errc=%0d err=%0d valid=%0d pos=%0d expected 255 261 0 0",
               err_count, ne, nv, position);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'b0000);
    hold(4'b0001, 10);
    hold(4'b0011, 10);
    hold(4'b0010, 10);
    hold(4'b0110, 10);
    hold(4'b0111, 10);
    checks++;
    if (position !== 16'd5 || binary_out !== 4'd5 || step_up !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: pos=%0d bin=%0d up=%0b expected 5 5 1", position, binary_out, step_up);
    end
    gray_in = 4'b0101;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (binary_out !== 4'd0 || position !== 16'd0 || err_count !== 8'd0 ||
        step_valid !== 1'b0 || step_err !== 1'b0 || step_up !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: bin=%0d pos=%0d errc=%0d sv=%0b se=%0b su=%0b expected all 0",
               binary_out, position, err_count, step_valid, step_err, step_up);
    end
    repeat (2) @(negedge clk);
    nv  = 0;
    ne  = 0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (binary_out !== 4'd6 || nv !== 0 || ne !== 0 || position !== 16'd0) begin
      errors++;
      $display("[TB] FAIL post_reset: bin=%0d valid=%0d err=%0d pos=%0d expected 6 0 0 0",
               binary_out, nv, ne, position);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both !== 0) begin
      errors++;
      $display("[TB] FAIL pulse_exclusive: both-high cycles=%0d expected 0", both);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    nv      = 0;
    ne      = 0;
    both    = 0;
    rst     = 1'b1;
    gray_in = '0;
    test_reset();
    test_up_steps();
    test_wrap();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
